if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/if_skid_buf.sv | 40 ++++
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, the canonical bubble instruction,
// the default reset fetch address and the fetch-stage state encoding.
package riscv_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_IL    = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    // addi x0,x0,0
    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RV_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched word and its address while decode
// is stalled. Clear has priority over load, load over drain.
module if_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] data_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            pc_q    <= pc_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction memory, registers the IF/ID
// outputs and parks one word in a skid buffer when decode stalls mid-fetch.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RV_RESET_PC,
    parameter logic [31:0] NOP_INSTR = RV_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [6:0]  opcode,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        imem_req_q;

    logic        skid_load, skid_drain, skid_clear;
    logic        skid_valid;
    logic [31:0] skid_data, skid_pc;

    // Redirect targets are word aligned; the low bits carry no information.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .data_i  (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .pc_o    (skid_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (redirect_valid) begin
            pc_d       = pc_align(redirect_pc);
            instr_d    = NOP_INSTR;
            if_valid_d = 1'b0;
            skid_clear = 1'b1;
            state_d    = IF_REQ;
        end else if (flush) begin
            instr_d    = NOP_INSTR;
            if_valid_d = 1'b0;
            skid_clear = 1'b1;
            state_d    = IF_REQ;
            // The parked word is dropped, so fetch it again from memory.
            if (state_q == IF_HOLD && skid_valid)
                pc_d = skid_pc;
        end else begin
            case (state_q)
                IF_IDLE: state_d = IF_REQ;
                IF_REQ: begin
                    if (imem_ready) begin
                        pc_d = pc_next(pc_q);
                        if (stall) begin
                            skid_load = 1'b1;
                            state_d   = IF_HOLD;
                        end else begin
                            instr_d    = imem_rdata;
                            if_pc_d    = pc_q;
                            if_valid_d = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_d    = NOP_INSTR;
                        if_valid_d = 1'b0;
                    end
                end
                IF_HOLD: begin
                    if (!skid_valid) begin
                        state_d = IF_REQ;
                    end else if (!stall) begin
                        instr_d    = skid_data;
                        if_pc_d    = skid_pc;
                        if_valid_d = 1'b1;
                        skid_drain = 1'b1;
                        state_d    = IF_REQ;
                    end
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IF_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            if_pc_q    <= 32'h0;
            if_valid_q <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            imem_req_q <= (state_d == IF_REQ);
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign opcode      = instr_q[6:0];
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a transaction-level fetch model predicts the
// registered outputs each cycle; a monitor compares them after every edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instruction;
    logic [6:0]  opcode;
    logic [31:0] if_pc;
    logic        if_valid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .Instruction    (Instruction),
        .opcode         (opcode),
        .if_pc          (if_pc),
        .if_valid       (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        req;
        logic [31:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: the next fetch address, words waiting for decode,
    // and the value currently presented to decode.
    logic        m_started;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic        m_valid;
    logic [31:0] pend_word[$];
    logic [31:0] pend_pc[$];

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_pc      = 32'h0;
        m_instr   = NOP;
        m_ifpc    = 32'h0;
        m_valid   = 1'b0;
        pend_word.delete();
        pend_pc.delete();
    endtask

    task automatic drive_and_model(input logic s, input logic r, input logic rv,
                                   input logic [31:0] rpc, input logic fl,
                                   input bit rand_word);
        logic [31:0] word;
        exp_t e;
        word = rand_word ? $urandom : tag(m_pc);
        stall          = s;
        imem_ready     = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        flush          = fl;
        imem_rdata     = word;

        if (rv) begin
            m_pc    = {rpc[31:2], 2'b00};
            m_instr = NOP;
            m_valid = 1'b0;
            pend_word.delete();
            pend_pc.delete();
        end else if (fl) begin
            m_instr = NOP;
            m_valid = 1'b0;
            if (pend_pc.size() > 0) m_pc = pend_pc[0];
            pend_word.delete();
            pend_pc.delete();
        end else if (!m_started) begin
            // first cycle after reset: nothing fetched yet
        end else if (pend_pc.size() > 0) begin
            if (!s) begin
                m_instr = pend_word.pop_front();
                m_ifpc  = pend_pc.pop_front();
                m_valid = 1'b1;
            end
        end else if (r) begin
            if (s) begin
                pend_word.push_back(word);
                pend_pc.push_back(m_pc);
            end else begin
                m_instr = word;
                m_ifpc  = m_pc;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end
        m_started = 1'b1;

        e.instr = m_instr;
        e.pc    = m_ifpc;
        e.valid = m_valid;
        e.req   = (pend_pc.size() == 0);
        e.addr  = m_pc;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic s, input logic r, input logic rv,
                        input logic [31:0] rpc, input logic fl, input bit rand_word);
        @(negedge clk);
        drive_and_model(s, r, rv, rpc, fl, rand_word);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tagname);
        chk({tagname, "_instr"},  Instruction, NOP);
        chk({tagname, "_opcode"}, {25'h0, opcode}, 32'h13);
        chk({tagname, "_if_pc"},  if_pc, 32'h0);
        chk({tagname, "_valid"},  {31'h0, if_valid}, 32'h0);
        chk({tagname, "_req"},    {31'h0, imem_req}, 32'h0);
        chk({tagname, "_addr"},   imem_addr, 32'h0);
    endtask

    // Monitor: one scoreboard entry is consumed after every clock edge.
    initial begin
        exp_t e;
        logic [6:0] exp_op;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                exp_op = e.instr[6:0];
                checks++;
                if (Instruction !== e.instr || if_pc !== e.pc || if_valid !== e.valid ||
                    imem_req !== e.req || imem_addr !== e.addr || opcode !== exp_op) begin
                    failures++;
                    $display("FAIL cycle_out t=%0t got instr=%h pc=%h v=%b req=%b addr=%h op=%h expected instr=%h pc=%h v=%b req=%b addr=%h op=%h",
                             $time, Instruction, if_pc, if_valid, imem_req, imem_addr, opcode,
                             e.instr, e.pc, e.valid, e.req, e.addr, exp_op);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #2 chk_reset_values("por");
        @(negedge clk);
        rst = 1'b0;
        drive_and_model(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Two back-to-back fetches (pc 0, 4), then stall with a word at 0x8.
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        after_edge();
        chk("stall_if_pc_frozen", if_pc, 32'h4);
        chk("stall_hold_req", {31'h0, imem_req}, 32'h0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        after_edge();
        chk("drain_if_pc", if_pc, 32'h8);
        chk("drain_instr", Instruction, tag(32'h8));
        step(0, 1, 0, 0, 0, 0);
        after_edge();
        chk("after_drain_if_pc", if_pc, 32'hC);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);

        // Redirect while stalled with a full skid buffer.
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h0000_1002, 0, 0);
        after_edge();
        chk("redir_valid", {31'h0, if_valid}, 32'h0);
        chk("redir_instr", Instruction, NOP);
        chk("redir_addr", imem_addr, 32'h1000);
        step(0, 1, 0, 0, 0, 0);
        after_edge();
        chk("redir_first_pc", if_pc, 32'h1000);

        // Flush in HOLD refetches the parked address.
        step(0, 0, 1, 32'h20, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        after_edge();
        chk("flush_valid", {31'h0, if_valid}, 32'h0);
        chk("flush_addr", imem_addr, 32'h20);
        step(0, 1, 0, 0, 0, 0);
        after_edge();
        chk("flush_refetch_pc", if_pc, 32'h20);

        // Address wrap at the top of memory.
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        after_edge();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

        // Asynchronous reset while waiting on memory.
        step(0, 0, 1, 32'h0000_0400, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_req", {31'h0, imem_req}, 32'h1);
        #2 rst = 1'b1;
        #1 chk_reset_values("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive_and_model(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int p_rd, p_fl, p_st, p_rdy;
            p_rd  = $urandom_range(0, 99);
            p_fl  = $urandom_range(0, 99);
            p_st  = $urandom_range(0, 99);
            p_rdy = $urandom_range(0, 99);
            step(p_st < 30, p_rdy < 70, p_rd < 5, $urandom, p_fl < 5, 1'b1);
        end
        step(0, 0, 0, 0, 0, 0);
        after_edge();
        chk("scoreboard_drained", sb_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
